// File: rtl/int_mult_add_pkg.sv
// Shared limits and width helpers for int_mult_add and its multiplier lanes.
package int_mult_add_pkg;

  localparam int IMA_INT_SIZE_MIN  = 2;
  localparam int IMA_INT_SIZE_MAX  = 16;
  localparam int IMA_NUM_MULT_MIN  = 1;
  localparam int IMA_NUM_MULT_MAX  = 16;
  localparam int IMA_PIPE_MAX      = 2;
  localparam int IMA_DOUT_SIZE_MIN = 8;
  localparam int IMA_DOUT_SIZE_MAX = 64;

  function automatic int clog2_int(input int v);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= v) return r;
    end
    return 31;
  endfunction

  // Operands are widened to int_size+1 bits signed, so the exact product needs 2*int_size+2.
  function automatic int prod_width(input int n);
    return 2 * n + 2;
  endfunction

  function automatic int sum_width(input int n, input int m);
    return 2 * n + 2 + clog2_int(m);
  endfunction

endpackage

// File: rtl/int_mult_add_lane.sv
// One int_size x int_size multiplier; each operand is sign- or zero-extended before multiplying.
module int_mult_add_lane
  import int_mult_add_pkg::*;
#(
  parameter int int_size       = 8,
  parameter int int_unsigned_a = 0,
  parameter int int_unsigned_b = 0
) (
  input  logic [int_size-1:0]             i_a,
  input  logic [int_size-1:0]             i_b,
  output logic [prod_width(int_size)-1:0] o_prod
);

  localparam int PW = prod_width(int_size);

  logic signed [int_size:0] a_ext;
  logic signed [int_size:0] b_ext;

  // One extra bit lets unsigned operands ride through a single signed multiplier.
  assign a_ext = {(int_unsigned_a != 0) ? 1'b0 : i_a[int_size-1], i_a};
  assign b_ext = {(int_unsigned_b != 0) ? 1'b0 : i_b[int_size-1], i_b};

  assign o_prod = PW'(PW'(a_ext) * PW'(b_ext));

endmodule

// File: rtl/int_mult_add.sv
// Sum of num_mult parallel products with optional input registers, sum pipeline and accumulator.
// Define INT_MULT_ADD_CHECK_EN to add simulation-only assertions.
module int_mult_add
  import int_mult_add_pkg::*;
#(
  parameter int int_size       = 8,
  parameter int num_mult       = 8,
  parameter int int_unsigned_a = 0,
  parameter int int_unsigned_b = 0,
  parameter int accumulate     = 0,
  parameter int in_reg_enable  = 0,
  parameter int pipeline_regs  = 0,
  parameter int dout_size      = 32
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [num_mult*int_size-1:0] i_din_a,
  input  logic [num_mult*int_size-1:0] i_din_b,
  input  logic                         i_in_reg_a_ce,
  input  logic                         i_in_reg_b_ce,
  input  logic                         i_in_reg_rstn,
  input  logic                         i_pipeline_ce,
  input  logic                         i_pipeline_rstn,
  input  logic                         i_load,
  output logic [dout_size-1:0]         o_dout
);

  localparam int TW = num_mult * int_size;
  localparam int PW = prod_width(int_size);
  localparam int SW = sum_width(int_size, num_mult);

  if (int_size < IMA_INT_SIZE_MIN || int_size > IMA_INT_SIZE_MAX) begin : g_bad_int_size
    $error("int_mult_add: int_size out of range");
  end
  if (num_mult < IMA_NUM_MULT_MIN || num_mult > IMA_NUM_MULT_MAX) begin : g_bad_num_mult
    $error("int_mult_add: num_mult out of range");
  end
  if (pipeline_regs < 0 || pipeline_regs > IMA_PIPE_MAX) begin : g_bad_pipe
    $error("int_mult_add: pipeline_regs out of range");
  end
  if (dout_size < IMA_DOUT_SIZE_MIN || dout_size > IMA_DOUT_SIZE_MAX) begin : g_bad_dout
    $error("int_mult_add: dout_size out of range");
  end
  if (!(int_unsigned_a inside {0, 1}) || !(int_unsigned_b inside {0, 1}) ||
      !(accumulate inside {0, 1}) || !(in_reg_enable inside {0, 1})) begin : g_bad_flag
    $error("int_mult_add: flag parameters must be 0 or 1");
  end

  // Every control input is folded here so configurations that ignore some of them stay lint-clean.
  logic unused_ctrl;
  assign unused_ctrl = ^{i_clk, i_reset, i_in_reg_a_ce, i_in_reg_b_ce, i_in_reg_rstn,
                         i_pipeline_ce, i_pipeline_rstn, i_load};

  logic [TW-1:0] a_op;
  logic [TW-1:0] b_op;

  if (in_reg_enable != 0) begin : g_in_reg
    logic [TW-1:0] a_q;
    logic [TW-1:0] b_q;
    always_ff @(posedge i_clk) begin
      if (i_reset || !i_in_reg_rstn) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        if (i_in_reg_a_ce) a_q <= i_din_a;
        if (i_in_reg_b_ce) b_q <= i_din_b;
      end
    end
    assign a_op = a_q;
    assign b_op = b_q;
  end else begin : g_no_in_reg
    assign a_op = i_din_a;
    assign b_op = i_din_b;
  end

  logic [PW-1:0] prod [num_mult];

  for (genvar k = 0; k < num_mult; k++) begin : g_lane
    int_mult_add_lane #(
      .int_size      (int_size),
      .int_unsigned_a(int_unsigned_a),
      .int_unsigned_b(int_unsigned_b)
    ) u_lane (
      .i_a   (a_op[k*int_size +: int_size]),
      .i_b   (b_op[k*int_size +: int_size]),
      .o_prod(prod[k])
    );
  end

  logic signed [SW-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < num_mult; k++) begin
      sum_c = sum_c + SW'($signed(prod[k]));
    end
  end

  logic signed [SW-1:0] sum_out;

  if (pipeline_regs != 0) begin : g_pipe
    logic signed [SW-1:0] stg [pipeline_regs];
    always_ff @(posedge i_clk) begin
      if (i_reset || !i_pipeline_rstn) begin
        for (int i = 0; i < pipeline_regs; i++) stg[i] <= '0;
      end else if (i_pipeline_ce) begin
        stg[0] <= sum_c;
        for (int i = 1; i < pipeline_regs; i++) stg[i] <= stg[i-1];
      end
    end
    assign sum_out = stg[pipeline_regs-1];
  end else begin : g_no_pipe
    assign sum_out = sum_c;
  end

  // The cast sign-extends when dout_size is wider and keeps the low bits when narrower.
  logic [dout_size-1:0] res;
  assign res = dout_size'(sum_out);

  if (accumulate != 0) begin : g_acc
    logic [dout_size-1:0] acc_q;
    always_ff @(posedge i_clk) begin
      if (i_reset || !i_pipeline_rstn) begin
        acc_q <= '0;
      end else if (i_pipeline_ce) begin
        acc_q <= i_load ? res : acc_q + res;
      end
    end
    assign o_dout = acc_q;

`ifdef INT_MULT_ADD_CHECK_EN
    logic [dout_size-1:0] acc_next;
    assign acc_next = acc_q + res;
    always @(posedge i_clk) begin
      if (!i_reset && i_pipeline_rstn && i_pipeline_ce && !i_load &&
          acc_q[dout_size-1] == res[dout_size-1] &&
          acc_next[dout_size-1] != acc_q[dout_size-1])
        $warning("int_mult_add: accumulator signed overflow");
    end
`endif
  end else begin : g_no_acc
    assign o_dout = res;
  end

`ifdef INT_MULT_ADD_CHECK_EN
  logic chk_armed;
  always_ff @(posedge i_clk) begin
    if (i_reset) chk_armed <= 1'b1;
  end

  always @(posedge i_clk) begin
    assert (int_size >= IMA_INT_SIZE_MIN && int_size <= IMA_INT_SIZE_MAX &&
            num_mult >= IMA_NUM_MULT_MIN && num_mult <= IMA_NUM_MULT_MAX &&
            pipeline_regs >= 0 && pipeline_regs <= IMA_PIPE_MAX &&
            dout_size >= IMA_DOUT_SIZE_MIN && dout_size <= IMA_DOUT_SIZE_MAX)
      else $error("int_mult_add: parameter out of range");
    if (chk_armed === 1'b1 && !i_reset) begin
      if (in_reg_enable != 0) begin
        assert (!$isunknown({i_in_reg_a_ce, i_in_reg_b_ce, i_in_reg_rstn}))
          else $error("int_mult_add: X on input register controls");
        assert (!(i_in_reg_a_ce && $isunknown(i_din_a)))
          else $error("int_mult_add: X on i_din_a while captured");
        assert (!(i_in_reg_b_ce && $isunknown(i_din_b)))
          else $error("int_mult_add: X on i_din_b while captured");
      end
      if (pipeline_regs != 0 || accumulate != 0) begin
        assert (!$isunknown({i_pipeline_ce, i_pipeline_rstn, i_load}))
          else $error("int_mult_add: X on pipeline controls");
      end
    end
  end
`endif

endmodule

// File: tb/tb_int_mult_add.sv
// Directed bench for int_mult_add across combinational, unsigned, narrow, accumulate and pipelined builds.
module tb_int_mult_add;

  logic        clk;
  logic        rst;
  logic [63:0] din_a;
  logic [63:0] din_b;
  logic        a_ce;
  logic        b_ce;
  logic        in_rstn;
  logic        pipe_ce;
  logic        pipe_rstn;
  logic        load;

  logic [31:0] dout_def;
  logic [31:0] dout_ua;
  logic [7:0]  dout_nar;
  logic [31:0] dout_acc;
  logic [31:0] dout_pipe;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int_mult_add u_def (
    .i_clk(clk), .i_reset(rst), .i_din_a(din_a), .i_din_b(din_b),
    .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce), .i_in_reg_rstn(in_rstn),
    .i_pipeline_ce(pipe_ce), .i_pipeline_rstn(pipe_rstn), .i_load(load), .o_dout(dout_def)
  );

  int_mult_add #(.int_unsigned_a(1)) u_ua (
    .i_clk(clk), .i_reset(rst), .i_din_a(din_a), .i_din_b(din_b),
    .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce), .i_in_reg_rstn(in_rstn),
    .i_pipeline_ce(pipe_ce), .i_pipeline_rstn(pipe_rstn), .i_load(load), .o_dout(dout_ua)
  );

  int_mult_add #(.dout_size(8)) u_nar (
    .i_clk(clk), .i_reset(rst), .i_din_a(din_a), .i_din_b(din_b),
    .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce), .i_in_reg_rstn(in_rstn),
    .i_pipeline_ce(pipe_ce), .i_pipeline_rstn(pipe_rstn), .i_load(load), .o_dout(dout_nar)
  );

  int_mult_add #(.accumulate(1)) u_acc (
    .i_clk(clk), .i_reset(rst), .i_din_a(din_a), .i_din_b(din_b),
    .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce), .i_in_reg_rstn(in_rstn),
    .i_pipeline_ce(pipe_ce), .i_pipeline_rstn(pipe_rstn), .i_load(load), .o_dout(dout_acc)
  );

  int_mult_add #(.in_reg_enable(1), .pipeline_regs(2)) u_pipe (
    .i_clk(clk), .i_reset(rst), .i_din_a(din_a), .i_din_b(din_b),
    .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce), .i_in_reg_rstn(in_rstn),
    .i_pipeline_ce(pipe_ce), .i_pipeline_rstn(pipe_rstn), .i_load(load), .o_dout(dout_pipe)
  );

  // Scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b);
    din_a = a;
    din_b = b;
  endtask

  logic [63:0] va      [4] = '{64'h7F7F7F7F7F7F7F7F, 64'h8080808080808080,
                               64'hFFFFFFFFFFFFFFFF, 64'h8100000000000003};
  logic [63:0] vb      [4] = '{64'h7F7F7F7F7F7F7F7F, 64'h8080808080808080,
                               64'h0202020202020202, 64'h7F00000000000005};
  logic [31:0] exp_def [4] = '{32'd129032, 32'd131072, 32'hFFFFFFF0, 32'hFFFFC10E};
  logic [31:0] exp_ua  [4] = '{32'd129032, 32'hFFFE0000, 32'd4080, 32'd16398};
  logic [7:0]  exp_nar [4] = '{8'h08, 8'h00, 8'hF0, 8'h0E};

  initial begin
    rst = 1'b1; a_ce = 1'b1; b_ce = 1'b1; in_rstn = 1'b1;
    pipe_ce = 1'b1; pipe_rstn = 1'b1; load = 1'b0;
    drive(64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F);

    // Reset state; the combinational build must ignore reset.
    step(2);
    check_eq("comb_in_reset", dout_def, 32'd129032);
    check_eq("acc_reset_val", dout_acc, 32'd0);
    check_eq("pipe_reset_val", dout_pipe, 32'd0);
    rst = 1'b0;

    // Combinational vectors, same cycle
    for (int i = 0; i < 4; i++) begin
      step(1);
      drive(va[i], vb[i]);
      #1;
      check_eq($sformatf("def_vec%0d", i), dout_def, exp_def[i]);
      check_eq($sformatf("ua_vec%0d", i), dout_ua, exp_ua[i]);
      check_eq($sformatf("nar_vec%0d", i), {24'd0, dout_nar}, {24'd0, exp_nar[i]});
    end

    // Pipelined build: latency 3
    drive(64'd0, 64'd0);
    do_reset();
    drive(64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F);
    step(1);
    check_eq("pipe_lat1", dout_pipe, 32'd0);
    step(1);
    check_eq("pipe_lat2", dout_pipe, 32'd0);
    step(1);
    check_eq("pipe_lat3", dout_pipe, 32'd129032);

    pipe_ce = 1'b0;
    drive(64'h8080808080808080, 64'h8080808080808080);
    step(3);
    check_eq("pipe_freeze", dout_pipe, 32'd129032);
    pipe_ce = 1'b1;
    step(2);
    check_eq("pipe_resume", dout_pipe, 32'd131072);

    pipe_rstn = 1'b0;
    step(1);
    check_eq("pipe_rstn_clear", dout_pipe, 32'd0);
    pipe_rstn = 1'b1;

    in_rstn = 1'b0;
    step(3);
    check_eq("in_rstn_priority", dout_pipe, 32'd0);
    in_rstn = 1'b1;

    a_ce = 1'b0;
    drive(64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F);
    step(3);
    check_eq("in_a_ce_hold", dout_pipe, 32'd0);
    a_ce = 1'b1;
    step(3);
    check_eq("in_a_ce_capture", dout_pipe, 32'd129032);

    // Accumulator: per-cycle sum of 10, load on the first cycle
    drive(64'd0, 64'd0);
    do_reset();
    drive(64'h0000000000000002, 64'h0000000000000005);
    load = 1'b1;
    #1;
    check_eq("comb_small", dout_def, 32'd10);
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(10 * i));
    for (int i = 0; i < 4; i++) begin
      step(1);
      load = 1'b0;
      check_eq($sformatf("acc_run%0d", i), dout_acc, exp_q.pop_front());
    end

    pipe_ce = 1'b0;
    step(1);
    check_eq("acc_hold", dout_acc, 32'd40);

    pipe_ce = 1'b1;
    load = 1'b1;
    rst = 1'b1;
    step(1);
    check_eq("acc_mid_reset", dout_acc, 32'd0);
    rst = 1'b0;
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/int_mult_add.md
INT_MULT_ADD -- requirements
Module: int_mult_add

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- int_size, 8: element width, legal 2..16.
- num_mult, 8: number of parallel products, legal 1..16.
- int_unsigned_a, 0: 1 means A elements are unsigned.
- int_unsigned_b, 0: 1 means B elements are unsigned.
- accumulate, 0: 1 enables the accumulator register.
- in_reg_enable, 0: 1 enables the input registers.
- pipeline_regs, 0: number of sum pipeline stages, legal 0..2.
- dout_size, 32: output width, legal 8..64.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- i_clk, in, 1: sole clock, rising edge.
- i_reset, in, 1: synchronous active-high reset.
- i_din_a, in, num_mult*int_size: packed A elements.
- i_din_b, in, num_mult*int_size: packed B elements.
- i_in_reg_a_ce, in, 1: A input register enable.
- i_in_reg_b_ce, in, 1: B input register enable.
- i_in_reg_rstn, in, 1: synchronous active-low clear of the input registers.
- i_pipeline_ce, in, 1: pipeline and accumulator enable.
- i_pipeline_rstn, in, 1: synchronous active-low clear of the pipeline and accumulator registers.
- i_load, in, 1: accumulator load (replace instead of add).
- o_dout, out, dout_size: sum-of-products result.

REQ-003 Element k SHALL occupy bits [k*int_size +: int_size] of i_din_a and i_din_b, with element 0 at the LSBs.

Function
REQ-004 Product k SHALL be a[k]*b[k] at full precision; each operand is sign- or zero-extended per int_unsigned_a/int_unsigned_b, and mixed signedness SHALL be handled exactly.
REQ-005 Sum SHALL be the exact total of all num_mult products, computed at width 2*int_size+2+clog2(num_mult).
REQ-006 o_dout SHALL be that value sign-extended to dout_size when wider, or truncated to its low dout_size bits (two's-complement wrap) when narrower.
REQ-007 With all of accumulate, in_reg_enable and pipeline_regs at 0, o_dout SHALL be purely combinational: same-cycle, no clock dependence, unaffected by i_reset.
REQ-008 Input stage (in_reg_enable=1): the A register SHALL capture i_din_a when i_in_reg_a_ce=1 and hold otherwise; the B register likewise with i_in_reg_b_ce.
REQ-009 i_in_reg_rstn=0 SHALL zero both input registers at the clock edge, taking priority over the enables.
REQ-010 Pipeline stages SHALL each advance only when i_pipeline_ce=1 and hold otherwise; i_pipeline_rstn=0 SHALL zero them, taking priority over i_pipeline_ce.
REQ-011 Accumulator (accumulate=1): when i_pipeline_ce=1, acc SHALL become sum if i_load=1, else acc+sum wrapped to dout_size; when i_pipeline_ce=0, acc SHALL hold; o_dout SHALL equal acc.
REQ-012 Latency from operands to o_dout SHALL be in_reg_enable+pipeline_regs+accumulate cycles, with all enables held at 1.
REQ-013 When the disable inputs are unused: input CEs and i_in_reg_rstn SHALL be ignored if in_reg_enable=0; i_pipeline_ce, i_pipeline_rstn and i_load SHALL be ignored if pipeline_regs=0 and accumulate=0.
REQ-014 Illegal parameter values SHALL stop elaboration with an error.

Reset
REQ-015 i_reset=1 SHALL zero every register (input, pipeline, accumulator) at the next edge, overriding all enables, clears and i_load.
REQ-016 o_dout SHALL read 0 after reset in any registered configuration; reset asserted mid-accumulation SHALL discard the running total.

Configuration
REQ-017 Macro INT_MULT_ADD_CHECK_EN SHALL add simulation-only assertions: parameter ranges, no X on enabled inputs after reset, and a warning on accumulator signed overflow.
REQ-018 Without INT_MULT_ADD_CHECK_EN the RTL SHALL be functionally identical with no checks.

Structure
REQ-019 Package int_mult_add_pkg SHALL hold the legal parameter limits and width-calculation functions for product and sum widths.
REQ-020 Sub-module int_mult_add_lane SHALL implement one signedness-aware int_size x int_size multiplier, instantiated num_mult times.

Verification
REQ-021 Defaults, all A=0x7F, all B=0x7F -> o_dout=129032 in the same cycle.
REQ-022 Defaults, all A=0x80, all B=0x80 -> 131072; all A=0xFF, all B=0x02 -> 0xFFFFFFF0 (-16).
REQ-023 int_unsigned_a=1, all A=0xFF, all B=0x02 -> 4080.
REQ-024 accumulate=1, per-cycle sum=10, i_load=1 on the first cycle then 0 -> o_dout 10, 20, 30, 40; i_reset mid-run -> 0 next cycle.
REQ-025 in_reg_enable=1, pipeline_regs=2 -> result after 3 cycles; i_pipeline_ce=0 freezes o_dout; i_pipeline_rstn=0 clears the stages.
